// File: rtl/shared_reg_arbiter_if.sv
// shared_reg_arbiter_if: requester-side bus of the shared register arbiter.
// master = requesters (drive req/lock/wdata), slave = arbiter.
`default_nettype none

interface shared_reg_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       lock;
    logic [NUM_REQ*WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]       gnt;
    logic [WIDTH-1:0]         q;
    logic [OW-1:0]            owner;
    logic                     q_upd;
    logic                     timeout;

    modport master (
        output req, lock, wdata,
        input  gnt, q, owner, q_upd, timeout
    );

    modport slave (
        input  req, lock, wdata,
        output gnt, q, owner, q_upd, timeout
    );
endinterface

`default_nettype wire

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbiter and sole write path of a shared WIDTH-bit register.
// Optional grant timeout is built when the macro ARB_TIMEOUT_EN is defined.
`default_nettype none

module shared_reg_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    shared_reg_arbiter_if.slave   bus
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT  = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_param_check
        $error("shared_reg_arbiter: parameter out of legal range");
    end

    // First requester at or after p, wrapping modulo NUM_REQ.
    function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [OW-1:0]      p);
        logic [OW:0] c;
        logic        found;
        rr_pick = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = {1'b0, p} + (OW+1)'(k);
            if (c >= (OW+1)'(NUM_REQ)) c = c - (OW+1)'(NUM_REQ);
            if (!found && r[c[OW-1:0]]) begin
                found   = 1'b1;
                rr_pick = c[OW-1:0];
            end
        end
    endfunction

    function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] i);
        next_idx = (i == OW'(NUM_REQ-1)) ? '0 : i + OW'(1);
    endfunction

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [OW-1:0]      idx_q, idx_d;
    logic [OW-1:0]      ptr_q, ptr_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic               q_upd_q, q_upd_d;

    logic               cur_req, cur_lock, force_rel;
    logic [OW-1:0]      ptr_inc, pick_idle, pick_rel;
    logic [NUM_REQ-1:0] others;

`ifdef ARB_TIMEOUT_EN
    logic [7:0]         hold_q, hold_d;
    logic               timeout_q, timeout_d;
    assign force_rel   = (hold_q == 8'(MAX_HOLD));
    assign bus.timeout = timeout_q;
`else
    assign force_rel   = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign cur_req   = bus.req[idx_q];
    assign cur_lock  = bus.lock[idx_q];
    assign ptr_inc   = next_idx(idx_q);
    // The releasing requester is excluded so it waits its round-robin turn.
    assign others    = bus.req & ~(NUM_REQ'(1) << idx_q);
    assign pick_idle = rr_pick(bus.req, ptr_q);
    assign pick_rel  = rr_pick(others, ptr_inc);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        q_d       = q_q;
        owner_d   = owner_q;
        q_upd_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    gnt_d   = NUM_REQ'(1) << pick_idle;
                    idx_d   = pick_idle;
                    state_d = S_GNT;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = 8'd1;
`endif
                end
            end
            S_GNT, S_LOCK: begin
                if (cur_req) begin
                    q_d     = bus.wdata[idx_q*WIDTH +: WIDTH];
                    owner_d = idx_q;
                    q_upd_d = 1'b1;
                end
                if (!cur_req || !cur_lock || force_rel) begin
                    ptr_d = ptr_inc;
`ifdef ARB_TIMEOUT_EN
                    timeout_d = cur_req && cur_lock && force_rel;
`endif
                    if (|others) begin
                        gnt_d   = NUM_REQ'(1) << pick_rel;
                        idx_d   = pick_rel;
                        state_d = S_GNT;
`ifdef ARB_TIMEOUT_EN
                        hold_d  = 8'd1;
`endif
                    end else begin
                        gnt_d   = '0;
                        state_d = S_IDLE;
`ifdef ARB_TIMEOUT_EN
                        hold_d  = 8'd0;
`endif
                    end
                end else begin
                    state_d = S_LOCK;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = hold_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            q_q       <= '0;
            owner_q   <= '0;
            q_upd_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            q_q       <= q_d;
            owner_q   <= owner_d;
            q_upd_q   <= q_upd_d;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.q     = q_q;
    assign bus.owner = owner_q;
    assign bus.q_upd = q_upd_q;

endmodule

`default_nettype wire

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin arbiter that shares a single WIDTH-bit data register (a bank of D flip-flops with synchronous active-high reset) between NUM_REQ requesters. Each requester raises a request with its write data; the block grants one requester at a time, captures the granted data into the shared register and reports the owner. A lock input lets the grantee hold the register for multi-cycle bursts. The block sits in front of the flip-flop bank and is its only write path.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..16.
- WIDTH, 8, width of the shared register.
- MAX_HOLD, 16, maximum grant length in cycles; legal range 2..255. Used only with ARB_TIMEOUT_EN.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset; the only reset.
- req  input  NUM_REQ  per-requester request; level, held until granted.
- lock  input  NUM_REQ  per-requester hold; sampled only from the current grantee.
- wdata  input  NUM_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- gnt  output  NUM_REQ  registered one-hot grant, or all zero.
- q  output  WIDTH  shared register contents.
- owner  output  max(1,$clog2(NUM_REQ))  index of the requester that last wrote q.
- q_upd  output  1  one-cycle pulse in the cycle after q was written.
- timeout  output  1  one-cycle pulse in the cycle after a forced release.

## Operation
- Reset values: gnt=0, q=0, owner=0, q_upd=0, timeout=0, round-robin pointer ptr=0, hold counter=0, state IDLE.
- States:
  - IDLE: no grant.
  - GNT: first granted cycle.
  - LOCK: further locked cycles.
- Arbitration: choose the first i with req[i]=1, scanning ptr, ptr+1, … modulo NUM_REQ.
- IDLE: if any req is set, gnt[i] is set at the next edge and the state moves to GNT; otherwise the block stays in IDLE.
- Write rule (GNT or LOCK): with gnt[i]=1 and req[i]=1, the edge loads q<=wdata[i], owner<=i and q_upd<=1.
  - If req[i]=0 the edge performs no write; the grant is released.
- Release: taken when req[i]=0 or lock[i]=0 at the write edge.
  - ptr<=(i+1) mod NUM_REQ.
  - If another req is pending (req[i] excluded), the next grantee is chosen from the new ptr and its gnt is set on the same edge, with the state moving to GNT. The released grant and the new grant never overlap.
  - If no other req is pending, gnt<=0 and the state moves to IDLE.
  - A requester that still has req set after release waits its round-robin turn. It is re-granted immediately only if no other req is pending.
- Hold: with lock[i]=1 and req[i]=1, gnt stays on i and the state moves to or stays in LOCK. q is rewritten every cycle.
- Other requesters' lock bits are ignored.
- Reset takes priority over every other event: any grant is dropped and no write happens on a reset edge.

## Timing
- Request to grant: req[i] set in cycle 0 while IDLE gives gnt[i]=1 in cycle 1.
- Grant to data: q updates at the end of cycle 1 and is visible with q_upd=1 in cycle 2.
- Back-to-back throughput: one unlocked grant per cycle when several requesters are pending.
- Hold counter: counts granted cycles from 1 in the GNT cycle. It clears on release and on reset.

## Configuration
- ARB_TIMEOUT_EN defined:
  - When the hold counter equals MAX_HOLD and lock[i] is still 1, the write on that edge still happens.
  - On that same edge the grant is released as for lock=0, ptr advances and timeout pulses in the following cycle.
- ARB_TIMEOUT_EN undefined: locks are unbounded, timeout is tied to 0, no hold counter is built, and MAX_HOLD is ignored.

## Test plan
- Reset, then req=4'b0001 with wdata[0]=8'hA5 → gnt=0001 in cycle 1; q=8'hA5, owner=0, q_upd=1 in cycle 2; gnt=0 in cycle 2.
- req=4'b1111 held, no lock → grants in order 0,1,2,3,0, one per cycle; q follows wdata[0..3] one cycle behind.
- req0 with lock0=1 for 5 cycles while req2=1 → gnt stays 0001 for 5 cycles and q is written 5 times; gnt=0100 on the cycle after lock0 falls.
- ARB_TIMEOUT_EN with MAX_HOLD=4, req0 and lock0 held high, req1=1 → gnt0 high exactly 4 cycles; timeout=1 with gnt=0010 on the next cycle.
- Grantee drops req mid-lock → no write on that edge, q_upd=0, grant moves on. reset asserted during LOCK → gnt=0, q=0 and owner=0 on the next cycle.
